dff_pipe: RTL and testbench
===========================

// Module: dff_pipe
// PURPOSE
// - Parametrised elastic register pipeline. Generalises the single-bit DFF to WIDTH bits and DEPTH stages.
// - Each stage has a valid bit and a valid/ready handshake, with bubble collapsing and sync flush.
// - Used for datapath retiming and for balancing latency between blocks, with full backpressure support.
// PARAMETERS
// - WIDTH    8    data bits per stage (>=1)
// - DEPTH    3    number of register stages (>=1); unstalled latency = DEPTH cycles
// - RST_VAL  0    WIDTH-bit value loaded into data regs on reset and on i_clr
// PORTS
// - i_clk    in   1                  clock; all state updates on posedge
// - i_rstn   in   1                  asynchronous active-low reset
// - i_clr    in   1                  synchronous flush of all stages
// - i_valid  in   1                  upstream data valid
// - i_data   in   WIDTH              upstream data
// - o_ready  out  1                  pipeline can accept i_data this cycle
// - o_valid  out  1                  last stage holds valid data
// - o_data   out  WIDTH              last-stage data
// - i_ready  in   1                  downstream accepts o_data this cycle
// - o_count  out  $clog2(DEPTH+1)    number of occupied stages, 0..DEPTH
// BEHAVIOUR
// - One clock domain. Reset is asynchronous and active-low:
//   - while i_rstn=0, all vld[k]=0 and all data[k]=RST_VAL;
//   - hence o_valid=0, o_data=RST_VAL, o_count=0.
// - Stage k (0=input side, DEPTH-1=output side) holds vld[k] and data[k].
// - rdy[DEPTH] = i_ready; rdy[k] = !vld[k] | rdy[k+1] (combinational chain); o_ready = rdy[0].
// - Transfers: input transfer = i_valid & o_ready; output transfer = o_valid & i_ready.
// - Stage k loads when rdy[k]=1:
//   - data[k] <= upstream data; vld[k] <= upstream valid;
//   - upstream of stage 0 is i_data/i_valid; upstream of stage k is stage k-1.
// - When rdy[k]=0, stage k holds data and valid unchanged. No data is lost or duplicated under stall.
// - Data regs load only on an accepted valid beat. An invalid beat clears vld but leaves data
//   (power-saving); the bench checks data only when valid.
// - Bubble collapsing: an empty stage accepts even when downstream is stalled,
//   so the pipe fills to DEPTH entries while i_ready=0.
// - Full: all vld=1 and i_ready=0 -> o_ready=0 in the same cycle.
// - Throughput: one beat per cycle whenever i_ready=1. A simultaneous in+out transfer on a full pipe is allowed.
// - Latency: a beat accepted in cycle t with i_ready held 1 appears on o_data with o_valid=1 in cycle t+DEPTH.
// - o_count: registered. Next value = count + in_xfer - out_xfer; it never wraps (bounded 0..DEPTH).
// - i_clr=1 at posedge:
//   - all vld<=0, data<=RST_VAL, count<=0;
//   - i_clr beats any same-cycle transfer, and an input beat offered that cycle is dropped;
//   - o_ready is still computed normally that cycle (no combinational path from i_clr).
// - Reset mid-operation: asynchronous clear regardless of stall state. First accept is possible on the first posedge after i_rstn rises.
// - DEPTH=1: a single register slot. o_ready = !o_valid | i_ready.
// STRUCTURE
// - Shared package dff_pkg: clog2-width helper for the count, default RST_VAL constant.
// - Sub-module dff_pipe_stage (WIDTH, RST_VAL): one valid+data register with i_rdy_dn/o_rdy_up.
// - Top-level: generate loop of DEPTH stages plus the occupancy counter.
// TESTING
// - Reset: assert i_rstn=0 mid-stream with 3 beats in flight -> o_valid=0, o_data=RST_VAL, o_count=0 immediately (async).
// - Streaming, DEPTH=3, WIDTH=8, i_ready=1, send 0x11,0x22,0x33 on consecutive cycles:
//   - outputs appear in cycles t+3,t+4,t+5 in order;
//   - o_ready stays 1 throughout.
// - Backpressure fill: i_ready=0, offer 0xA0..0xA4:
//   - 0xA0..0xA2 accepted, o_count=3, then o_ready=0;
//   - release i_ready -> A0,A1,A2 drain in order, no loss or duplicate.
// - Bubble collapse: beats at t and t+2 with i_ready=0 -> both held, o_count=2.
//   Release -> back-to-back output.
// - Flush: pipe holds 2 beats, pulse i_clr with i_valid=1, i_data=0x5C:
//   - next cycle o_count=0, o_valid=0;
//   - 0x5C never appears.
// - Full pass-through: pipe full, i_valid=1 and i_ready=1 for 10 cycles:
//   - o_count stays 3;
//   - the output sequence equals the input sequence delayed by 3 accepted beats.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared definitions for the elastic register pipeline: the occupancy-count
// width helper and the default data reset value.
package dff_pkg;

    localparam int unsigned DFF_RST_VAL_DEF = 0;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int dff_cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic slot of the pipeline: a valid bit plus a data register. The slot
// accepts whenever it is empty or the slot below is taking its contents.
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DFF_RST_VAL_DEF)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic             i_vld_up,
    input  logic [WIDTH-1:0] i_data_up,
    input  logic             i_rdy_dn,
    output logic             o_rdy_up,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    assign o_rdy_up = !vld_q || i_rdy_dn;
    assign o_vld    = vld_q;
    assign o_data   = data_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_q  <= 1'b0;
            data_q <= RST_VAL;
        end else if (i_clr) begin
            vld_q  <= 1'b0;
            data_q <= RST_VAL;
        end else if (o_rdy_up) begin
            vld_q <= i_vld_up;
            // Bubbles clear the valid bit but leave the data register idle.
            if (i_vld_up) begin
                data_q <= i_data_up;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready handshake, bubble
// collapsing, synchronous flush and a registered occupancy count.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DFF_RST_VAL_DEF)
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_clr,
    input  logic                          i_valid,
    input  logic [WIDTH-1:0]              i_data,
    output logic                          o_ready,
    output logic                          o_valid,
    output logic [WIDTH-1:0]              o_data,
    input  logic                          i_ready,
    output logic [dff_cnt_w(DEPTH)-1:0]   o_count
);

    localparam int CW = dff_cnt_w(DEPTH);

    logic             vld  [DEPTH];
    logic [WIDTH-1:0] data [DEPTH];
    logic             rdy  [DEPTH+1];

    assign rdy[DEPTH] = i_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_vld;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_vld  = i_valid;
            assign up_data = i_data;
        end else begin : g_body
            assign up_vld  = vld[k-1];
            assign up_data = data[k-1];
        end

        dff_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .i_clk     (i_clk),
            .i_rstn    (i_rstn),
            .i_clr     (i_clr),
            .i_vld_up  (up_vld),
            .i_data_up (up_data),
            .i_rdy_dn  (rdy[k+1]),
            .o_rdy_up  (rdy[k]),
            .o_vld     (vld[k]),
            .o_data    (data[k])
        );
    end

    assign o_ready = rdy[0];
    assign o_valid = vld[DEPTH-1];
    assign o_data  = data[DEPTH-1];

    logic          in_xfer;
    logic          out_xfer;
    logic [CW-1:0] count_q;

    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;
    assign o_count  = count_q;

    // Transfers are gated by the handshake, so the count stays within 0..DEPTH.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count_q <= '0;
        end else if (i_clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe (WIDTH=8, DEPTH=3): FIFO-queue scoreboard checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             i_clk = 1'b0;
    logic             i_rstn;
    logic             i_clr;
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             i_ready;
    logic [1:0]       o_count;

    int n_cmp = 0;
    int n_bad = 0;

    dff_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (8'h00)
    ) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_clr   (i_clr),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard: the pipe behaves as a FIFO of accepted beats, capacity DEPTH.
    logic [WIDTH-1:0] q[$];
    logic             exp_rdy;
    logic             mdl_in;
    logic             mdl_out;

    always @(negedge i_rstn) q.delete();

    always @(negedge i_clk) begin
        if (i_rstn) begin
            exp_rdy = (q.size() < DEPTH) || i_ready;
            chk("sb_count", 32'(o_count), 32'(q.size()));
            chk("sb_ready", 32'(o_ready), 32'(exp_rdy));
            if (q.size() == 0) chk("sb_valid_empty", 32'(o_valid), 32'd0);
            if (q.size() == DEPTH) chk("sb_valid_full", 32'(o_valid), 32'd1);
            if (o_valid && q.size() > 0) chk("sb_data", 32'(o_data), 32'(q[0]));
            if (i_clr) begin
                q.delete();
            end else begin
                mdl_in  = i_valid && exp_rdy;
                mdl_out = o_valid && i_ready;
                if (mdl_out && q.size() > 0) void'(q.pop_front());
                if (mdl_in) q.push_back(i_data);
            end
        end
    end

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (DEPTH + 2) tick();
    endtask

    logic [WIDTH-1:0] got [$];
    int               acc;
    logic             took;

    initial begin
        i_rstn  = 1'b0;
        i_clr   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;
        repeat (2) tick();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data",  32'(o_data),  32'h00);
        chk("rst_count", 32'(o_count), 32'd0);
        i_rstn = 1'b1;
        tick();

        // Streaming: 11,22,33 back to back, latency DEPTH
        i_valid = 1'b1; i_data = 8'h11;
        tick();
        i_data = 8'h22;
        chk("stream_ready1", 32'(o_ready), 32'd1);
        tick();
        i_data = 8'h33;
        chk("stream_ready2", 32'(o_ready), 32'd1);
        tick();
        chk("stream_out0_v", 32'(o_valid), 32'd1);
        chk("stream_out0_d", 32'(o_data),  32'h11);
        i_valid = 1'b0;
        tick();
        chk("stream_out1_d", 32'(o_data),  32'h22);
        tick();
        chk("stream_out2_d", 32'(o_data),  32'h33);
        tick();
        chk("stream_end_v",  32'(o_valid), 32'd0);
        drain();

        // Backpressure fill: offer A0..A4 with i_ready low
        i_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            i_valid = (acc < 5);
            i_data  = 8'hA0 + 8'(acc);
            #1;
            took = i_valid && o_ready;
            tick();
            if (took) acc++;
        end
        chk("fill_accepted", 32'(acc), 32'd3);
        chk("fill_count",    32'(o_count), 32'd3);
        chk("fill_ready",    32'(o_ready), 32'd0);
        chk("fill_head",     32'(o_data),  32'hA0);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        chk("fill_drain1", 32'(o_data), 32'hA1);
        tick();
        chk("fill_drain2", 32'(o_data), 32'hA2);
        tick();
        chk("fill_drain_v", 32'(o_valid), 32'd0);
        drain();

        // Bubble collapse: beats two cycles apart while stalled
        i_ready = 1'b0;
        i_valid = 1'b1; i_data = 8'hB0;
        tick();
        i_valid = 1'b0;
        tick();
        i_valid = 1'b1; i_data = 8'hB1;
        tick();
        i_valid = 1'b0;
        repeat (2) tick();
        chk("bubble_count", 32'(o_count), 32'd2);
        chk("bubble_head",  32'(o_data),  32'hB0);
        i_ready = 1'b1;
        tick();
        chk("bubble_b2b_v", 32'(o_valid), 32'd1);
        chk("bubble_b2b_d", 32'(o_data),  32'hB1);
        drain();

        // Flush with a beat offered in the same cycle
        i_ready = 1'b0;
        i_valid = 1'b1; i_data = 8'hC0;
        tick();
        i_data = 8'hC1;
        tick();
        i_clr = 1'b1; i_data = 8'h5C;
        #1;
        chk("flush_ready", 32'(o_ready), 32'd1);
        tick();
        i_clr = 1'b0; i_valid = 1'b0;
        chk("flush_count", 32'(o_count), 32'd0);
        chk("flush_valid", 32'(o_valid), 32'd0);
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("flush_no_5c", 32'(o_valid), 32'd0);
        end

        // Full pass-through: fill with D0..D2, then stream E0..E9 with i_ready high
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_data = 8'hD0 + 8'(i);
            tick();
        end
        chk("pass_full_count", 32'(o_count), 32'd3);
        i_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1; i_data = 8'hE0 + 8'(i);
            #1;
            if (o_valid) got.push_back(o_data);
            tick();
            chk("pass_count", 32'(o_count), 32'd3);
        end
        chk("pass_n_out", 32'(got.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < got.size())
                chk("pass_seq", 32'(got[k]), (k < 3) ? 32'(8'hD0 + 8'(k)) : 32'(8'hE0 + 8'(k - 3)));
        end
        drain();

        // Asynchronous reset with three beats in flight
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_data = 8'h70 + 8'(i);
            tick();
        end
        chk("arst_pre_count", 32'(o_count), 32'd3);
        i_rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_data",  32'(o_data),  32'h00);
        chk("arst_count", 32'(o_count), 32'd0);
        #1;
        i_rstn  = 1'b1;
        i_ready = 1'b1;
        i_valid = 1'b1; i_data = 8'h99;
        tick();
        i_valid = 1'b0;
        chk("arst_first_accept", 32'(o_count), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
